// File: rtl/bus_arbiter.sv
// Two-master bus arbiter and sequencer for the SoC data bus.
// Serialises M0/M1 transactions onto the shared RAM/peripheral slave bus, one at a time,
// and returns a one-cycle ack with read data and an error flag to the winning master.
// Optional macro BUS_ARB_RR_EN: round-robin arbitration instead of fixed priority M0 > M1.
module bus_arbiter #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned RAM_ADDRW = 10,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            m0_req,
    input  logic [XLEN-1:0] m0_addr,
    input  logic            m0_wrEn,
    input  logic            m0_rdEn,
    input  logic [XLEN-1:0] m0_wrData,
    input  logic [3:0]      m0_ramMode,
    output logic            m0_ack,
    output logic [XLEN-1:0] m0_rdData,
    output logic            m0_err,
    input  logic            m1_req,
    input  logic [XLEN-1:0] m1_addr,
    input  logic            m1_wrEn,
    input  logic            m1_rdEn,
    input  logic [XLEN-1:0] m1_wrData,
    input  logic [3:0]      m1_ramMode,
    output logic            m1_ack,
    output logic [XLEN-1:0] m1_rdData,
    output logic            m1_err,
    output logic [XLEN-1:0] s_addr,
    output logic [XLEN-1:0] s_wrData,
    output logic [3:0]      s_ramMode,
    output logic            s_wrEn,
    output logic            s_ramRdEn,
    output logic            s_periRdEn,
    input  logic [XLEN-1:0] s_rdData,
    input  logic            s_rdDataEn,
    output logic            busy
);

    localparam int unsigned CntW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e            state_q, state_d;
    logic              gnt_q, gnt_d;      // 0 = M0, 1 = M1
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [3:0]        mode_q, mode_d;
    logic              wr_q, wr_d;
    logic              rd_q, rd_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [CntW-1:0]   cnt_inc;

    logic              any_req;
    logic              win;
    logic              illegal;
    logic              ram_sel;

    assign any_req = m0_req | m1_req;
    assign illegal = (wr_q == rd_q);
    assign ram_sel = (addr_q[XLEN-1:RAM_ADDRW] == '0);
    assign cnt_inc = cnt_q + CntW'(1);

`ifdef BUS_ARB_RR_EN
    logic last_q, last_d;                 // master granted most recently

    // On contention the master not granted last wins; a lone requester always wins.
    assign win = m1_req & (~m0_req | ~last_q);

    // Round-robin pointer, updated on entry to ISSUE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b0;
        end else begin
            last_q <= last_d;
        end
    end

    // Pointer next-state: remember the winner when a grant is made
    always_comb begin
        last_d = last_q;
        if (state_q == StIdle && any_req) begin
            last_d = win;
        end
    end
`else
    // Fixed priority: M1 only wins when M0 is not requesting
    assign win = m1_req & ~m0_req;
`endif

    // State and transaction registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            gnt_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            mode_q  <= '0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            mode_q  <= mode_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: grant/latch in IDLE, issue, wait for data or timeout, respond
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        mode_d  = mode_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = '0;

        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    gnt_d   = win;
                    addr_d  = win ? m1_addr    : m0_addr;
                    wdata_d = win ? m1_wrData  : m0_wrData;
                    mode_d  = win ? m1_ramMode : m0_ramMode;
                    wr_d    = win ? m1_wrEn    : m0_wrEn;
                    rd_d    = win ? m1_rdEn    : m0_rdEn;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (illegal) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = StResp;
                end else if (wr_q) begin
                    state_d = StResp;
                end else if (s_rdDataEn) begin
                    rdata_d = s_rdData;
                    state_d = StResp;
                end else begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (s_rdDataEn) begin
                    rdata_d = s_rdData;
                    state_d = StResp;
                end else if (TIMEOUT != 0 && cnt_inc == CntW'(TIMEOUT)) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs decoded from registered state only, so reset clears them immediately
    always_comb begin
        s_addr     = '0;
        s_wrData   = '0;
        s_ramMode  = '0;
        s_wrEn     = 1'b0;
        s_ramRdEn  = 1'b0;
        s_periRdEn = 1'b0;
        m0_ack     = 1'b0;
        m0_rdData  = '0;
        m0_err     = 1'b0;
        m1_ack     = 1'b0;
        m1_rdData  = '0;
        m1_err     = 1'b0;
        busy       = (state_q != StIdle);

        if (state_q == StIssue || state_q == StWait) begin
            s_addr    = addr_q;
            s_wrData  = wdata_q;
            s_ramMode = mode_q;
        end
        if (state_q == StIssue && !illegal) begin
            s_wrEn     = wr_q;
            s_ramRdEn  = rd_q & ram_sel;
            s_periRdEn = rd_q & ~ram_sel;
        end
        if (state_q == StResp) begin
            if (gnt_q) begin
                m1_ack    = 1'b1;
                m1_rdData = rdata_q;
                m1_err    = err_q;
            end else begin
                m0_ack    = 1'b1;
                m0_rdData = rdata_q;
                m0_err    = err_q;
            end
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter (default parameters).
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_wrEn, m0_rdEn, m0_ack, m0_err;
    logic [31:0] m0_addr, m0_wrData, m0_rdData;
    logic [3:0]  m0_ramMode;
    logic        m1_req, m1_wrEn, m1_rdEn, m1_ack, m1_err;
    logic [31:0] m1_addr, m1_wrData, m1_rdData;
    logic [3:0]  m1_ramMode;
    logic [31:0] s_addr, s_wrData, s_rdData;
    logic [3:0]  s_ramMode;
    logic        s_wrEn, s_ramRdEn, s_periRdEn, s_rdDataEn, busy;

    int checks   = 0;
    int failures = 0;
    int peri_cnt = 0;
    int waits;

    always #5 clk = ~clk;

    bus_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .m0_req     (m0_req),
        .m0_addr    (m0_addr),
        .m0_wrEn    (m0_wrEn),
        .m0_rdEn    (m0_rdEn),
        .m0_wrData  (m0_wrData),
        .m0_ramMode (m0_ramMode),
        .m0_ack     (m0_ack),
        .m0_rdData  (m0_rdData),
        .m0_err     (m0_err),
        .m1_req     (m1_req),
        .m1_addr    (m1_addr),
        .m1_wrEn    (m1_wrEn),
        .m1_rdEn    (m1_rdEn),
        .m1_wrData  (m1_wrData),
        .m1_ramMode (m1_ramMode),
        .m1_ack     (m1_ack),
        .m1_rdData  (m1_rdData),
        .m1_err     (m1_err),
        .s_addr     (s_addr),
        .s_wrData   (s_wrData),
        .s_ramMode  (s_ramMode),
        .s_wrEn     (s_wrEn),
        .s_ramRdEn  (s_ramRdEn),
        .s_periRdEn (s_periRdEn),
        .s_rdData   (s_rdData),
        .s_rdDataEn (s_rdDataEn),
        .busy       (busy)
    );

    // Count peripheral read strobes, sampled away from the active edge
    always @(negedge clk) begin
        if (s_periRdEn) peri_cnt <= peri_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; sample and drive 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        m0_req = 0; m0_wrEn = 0; m0_rdEn = 0; m0_addr = 0; m0_wrData = 0; m0_ramMode = 0;
        m1_req = 0; m1_wrEn = 0; m1_rdEn = 0; m1_addr = 0; m1_wrData = 0; m1_ramMode = 0;
        s_rdData = 0; s_rdDataEn = 0;
        step(); step();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_acks", {30'd0, m0_ack, m1_ack}, 32'd0);
        check("rst_saddr", s_addr, 32'd0);
        rst = 1'b0;
        step();

        // M0 write to RAM
        m0_req = 1; m0_wrEn = 1; m0_addr = 32'h10; m0_wrData = 32'hA5A5A5A5; m0_ramMode = 4'b0010;
        step();
        check("wr_strobes", {29'd0, s_wrEn, s_ramRdEn, s_periRdEn}, 32'b100);
        check("wr_saddr", s_addr, 32'h10);
        check("wr_sdata", s_wrData, 32'hA5A5A5A5);
        check("wr_smode", {28'd0, s_ramMode}, 32'b0010);
        check("wr_noack_yet", {31'd0, m0_ack}, 32'd0);
        step();
        check("wr_ack", {29'd0, m0_ack, m0_err, m1_ack}, 32'b100);
        check("wr_rddata", m0_rdData, 32'd0);
        check("wr_strobe_off", {31'd0, s_wrEn}, 32'd0);
        m0_req = 0; m0_wrEn = 0;
        step();
        check("wr_idle", {30'd0, busy, m0_ack}, 32'd0);

        // M1 peripheral read, response after 3 WAIT cycles
        peri_cnt = 0;
        m1_req = 1; m1_rdEn = 1; m1_addr = 32'h402;
        step();
        check("rd_strobes", {29'd0, s_wrEn, s_ramRdEn, s_periRdEn}, 32'b001);
        check("rd_saddr", s_addr, 32'h402);
        m1_addr = 32'hFFF;  // change after grant must be ignored
        for (int i = 0; i < 3; i++) begin
            step();
            check("rd_wait_noack", {30'd0, m1_ack, s_periRdEn}, 32'd0);
        end
        check("rd_addr_held", s_addr, 32'h402);
        step();
        s_rdDataEn = 1; s_rdData = 32'h41;
        step();
        s_rdDataEn = 0; s_rdData = 0;
        check("rd_ack", {29'd0, m1_ack, m1_err, m0_ack}, 32'b100);
        check("rd_data", m1_rdData, 32'h41);
        check("rd_peri_pulses", peri_cnt, 32'd1);
        m1_req = 0; m1_rdEn = 0;
        step();

        // Simultaneous write requests: M0 first, then M1
        m0_req = 1; m0_wrEn = 1; m0_addr = 32'h100; m0_wrData = 32'h1;
        m1_req = 1; m1_wrEn = 1; m1_addr = 32'h200; m1_wrData = 32'h2;
        step();
        check("arb_first_addr", s_addr, 32'h100);
        step();
        check("arb_first_ack", {30'd0, m0_ack, m1_ack}, 32'b10);
        m0_req = 0; m0_wrEn = 0;
        step();
        check("arb_idle_gap", {31'd0, busy}, 32'd0);
        step();
        check("arb_second_addr", s_addr, 32'h200);
        check("arb_second_data", s_wrData, 32'h2);
        step();
        check("arb_second_ack", {30'd0, m0_ack, m1_ack}, 32'b01);
        m1_req = 0; m1_wrEn = 0;
        step();

        // RAM read with no response: timeout after 16 WAIT cycles
        m0_req = 1; m0_rdEn = 1; m0_addr = 32'h20;
        s_rdData = 32'hDEAD;
        step();
        check("to_strobes", {29'd0, s_wrEn, s_ramRdEn, s_periRdEn}, 32'b010);
        waits = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (m0_ack) break;
            waits++;
        end
        check("to_wait_cycles", waits, 32'd16);
        check("to_ack_err", {30'd0, m0_ack, m0_err}, 32'b11);
        check("to_rddata", m0_rdData, 32'd0);
        m0_req = 0; m0_rdEn = 0;
        step();

        // Stray read-data enable in IDLE is ignored
        s_rdDataEn = 1;
        step();
        s_rdDataEn = 0; s_rdData = 0;
        check("stray_idle", {29'd0, busy, m0_ack, m1_ack}, 32'd0);

        // Illegal op: wrEn and rdEn both set
        m1_req = 1; m1_wrEn = 1; m1_rdEn = 1; m1_addr = 32'h30;
        step();
        check("ill_no_strobe", {29'd0, s_wrEn, s_ramRdEn, s_periRdEn}, 32'd0);
        step();
        check("ill_ack_err", {30'd0, m1_ack, m1_err}, 32'b11);
        check("ill_rddata", m1_rdData, 32'd0);
        m1_req = 0; m1_wrEn = 0; m1_rdEn = 0;
        step();

        // Reset during WAIT drops the transaction
        m0_req = 1; m0_rdEn = 1; m0_addr = 32'h404;
        step();
        step();
        check("rstw_in_wait", {31'd0, busy}, 32'd1);
        rst = 1; m0_req = 0; m0_rdEn = 0;
        #1;
        check("rstw_outputs", {28'd0, busy, s_periRdEn, m0_ack, m1_ack}, 32'd0);
        check("rstw_saddr", s_addr, 32'd0);
        step(); step();
        check("rstw_no_ack", {30'd0, m0_ack, m1_ack}, 32'd0);
        rst = 0;
        step();

        // Next request after reset: read with same-cycle response, ack at N+2
        m0_req = 1; m0_rdEn = 1; m0_addr = 32'h8;
        step();
        check("post_rst_strobe", {29'd0, s_wrEn, s_ramRdEn, s_periRdEn}, 32'b010);
        s_rdDataEn = 1; s_rdData = 32'h1234;
        step();
        s_rdDataEn = 0; s_rdData = 0;
        check("post_rst_ack", {30'd0, m0_ack, m0_err}, 32'b10);
        check("post_rst_data", m0_rdData, 32'h1234);
        m0_req = 0; m0_rdEn = 0;
        step();
        check("final_idle", {31'd0, busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Two-master arbiter and sequencer for the SoC data bus. It shares the RAM and peripheral slaves (UART, IO port) between the core (M0) and a second master (M1, e.g. DMA or debug).
- Issues one transaction at a time, decodes RAM vs. peripheral read strobes, and waits for the slave's read-data enable.
- Returns an ack, data and error per master, with a read timeout.

Parameters:
- XLEN, 32, data/address width.
- RAM_ADDRW, 10, word-address width of the RAM window. Addr[XLEN-1:RAM_ADDRW]==0 selects RAM.
- TIMEOUT, 16, max cycles in WAIT before an error ack. 0 = wait forever.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- m0_req, m1_req  in  1  request; held with its fields until ack
- m0_addr, m1_addr  in  XLEN  address
- m0_wrEn, m1_wrEn  in  1  write request
- m0_rdEn, m1_rdEn  in  1  read request
- m0_wrData, m1_wrData  in  XLEN  write data
- m0_ramMode, m1_ramMode  in  4  {byte,half,word,unsigned}
- m0_ack, m1_ack  out  1  one-cycle completion pulse
- m0_rdData, m1_rdData  out  XLEN  read data, valid with ack
- m0_err, m1_err  out  1  error flag, valid with ack
- s_addr  out  XLEN  slave address
- s_wrData  out  XLEN  slave write data
- s_ramMode  out  4  slave access mode
- s_wrEn  out  1  write strobe, broadcast to all slaves
- s_ramRdEn  out  1  RAM read strobe
- s_periRdEn  out  1  peripheral read strobe
- s_rdData  in  XLEN  muxed slave read data
- s_rdDataEn  in  1  OR of slave output enables
- busy  out  1  state != IDLE

Behaviour:
- Reset:
  - State IDLE; all outputs 0; timeout counter 0; RR pointer set to M0.
  - Asserting rst mid-transaction drops the transaction; no ack is issued.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - At the edge with any req high, latch winner id, addr, wrData, ramMode and op. Go to ISSUE.
  - Default arbitration is fixed priority, M0 > M1.
- ISSUE (exactly 1 cycle):
  - Drive s_addr/s_wrData/s_ramMode from the latched values.
  - Exactly one strobe is high: s_wrEn (write), s_ramRdEn (read, RAM window) or s_periRdEn (read, otherwise).
  - Write → RESP.
  - Read with s_rdDataEn high in this cycle → capture s_rdData, go to RESP.
  - Otherwise → WAIT.
- Illegal op (wrEn&rdEn, or neither):
  - No strobe in ISSUE.
  - Go to RESP with err=1 and rdData=0.
- WAIT:
  - Strobes low; s_addr held.
  - When s_rdDataEn is high, capture s_rdData and go to RESP.
  - Counter increments each WAIT cycle. When it reaches TIMEOUT (TIMEOUT>0), go to RESP with err=1 and rdData=0.
  - Counter clears on leaving WAIT.
- RESP (1 cycle):
  - Winner's ack=1; rdData valid (0 for writes); err as set. The other master's ack stays 0.
  - All reqs are ignored this cycle. Next state is IDLE.
- Latency:
  - Write: req sampled at edge N; strobe in cycle N+1; ack in N+2.
  - Read with same-cycle response: ack in N+2. Otherwise ack 1 cycle after the s_rdDataEn cycle.
- Throughput: back-to-back transactions have a minimum of 3 cycles (IDLE sample, ISSUE, RESP).
- Stray s_rdDataEn in IDLE/RESP is ignored.
- Changes to a master's fields after grant are ignored (latched copy).
- Loser of simultaneous reqs stays pending and is granted at the next IDLE edge.

Optional Feature:
- BUS_ARB_RR_EN defined:
  - Round-robin arbitration. On simultaneous reqs, the master not granted last wins.
  - The pointer updates on entry to ISSUE.
  - A single requester always wins.
- Undefined: fixed priority M0 > M1; M1 can starve.

Test Plan:
- M0 write addr=0x10, data=0xA5A5A5A5 → s_wrEn=1 for 1 cycle with those values, s_ramRdEn=s_periRdEn=0; m0_ack one cycle later, m0_err=0.
- M1 read addr=0x402; slave returns s_rdDataEn with 0x41 after 3 WAIT cycles → s_periRdEn pulse once; m1_ack with m1_rdData=0x41, 1 cycle after s_rdDataEn.
- M0 and M1 req same edge, no macro → M0 served first, M1 next; with BUS_ARB_RR_EN and M0 last granted → M1 first.
- Read addr=0x20, no slave response, TIMEOUT=16 → ack after 16 WAIT cycles with err=1, rdData=0.
- Req with wrEn=rdEn=1 → no strobe, ack with err=1.
- rst asserted during WAIT → all outputs 0 immediately; no ack; next req processed normally after release.
